avalon_aes_master: RTL and testbench

Avalon-MM initiator that drives the AES decryption register interface from the fabric side. On a start request it writes the 128-bit key and encrypted message into the slave register map, sets the start register, polls the done register, reads back the decrypted message and clears start. It lets hardware such as a test harness or a DMA-less datapath use the AES core without the NIOS II processor.

---
 rtl/avalon_aes_master.sv | 201 ++++++++++++++++++++
 tb/tb_avalon_aes_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_aes_master.sv
// avalon_aes_master
//   Avalon-MM initiator that runs one AES decryption job on the register-mapped
//   AES slave: it writes the key (words 0-3), writes the encrypted message
//   (words 4-7), sets start (word 14), polls done (word 15), reads the
//   plaintext (words 8-11) and then clears start.
//
// Ports
//   CLK, RESET         rising-edge clock, asynchronous active-low reset
//   START              job request, sampled only while idle
//   KEY, MSG_ENC       128-bit operands, captured when START is accepted
//   MSG_DEC            plaintext, updated only when a job succeeds
//   BUSY / DONE / ERR  job status; ERR flags a done-poll timeout
//   AVM_*              Avalon-MM master port (all strobes registered)
//
// Parameters
//   POLL_GAP    idle cycles between done polls (0 = back-to-back polls)
//   POLL_LIMIT  done polls allowed before giving up (>= 1)
module avalon_aes_master #(
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 65535
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [127:0] MSG_ENC,
  output logic [127:0] MSG_DEC,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic         AVM_CS,
  output logic         AVM_READ,
  output logic         AVM_WRITE,
  output logic [3:0]   AVM_BYTE_EN,
  output logic [3:0]   AVM_ADDR,
  output logic [31:0]  AVM_WRITEDATA,
  input  logic [31:0]  AVM_READDATA,
  input  logic         AVM_WAITREQUEST
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_KEY, S_WR_MSG, S_WR_START, S_POLL,
    S_GAP, S_RD_DEC, S_CLR_START, S_FIN
  } state_t;

  state_t           state, nstate;
  logic [1:0]       idx, nidx;
  logic [PCW-1:0]   poll_cnt, npoll;
  logic [GW-1:0]    gap_cnt, ngap;
  logic [127:0]     key_q, msg_q;
  logic [31:0]      sh0, sh1, sh2;
  logic             cap, set_err, load_dec, sh_we;
  logic             nrd, nwr;
  logic [3:0]       naddr;
  logic [31:0]      nwd;
  logic             xfer;

  // Word 0 of each 128-bit operand is its most significant 32 bits.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  assign xfer = (AVM_READ | AVM_WRITE) & ~AVM_WAITREQUEST;
  assign BUSY = (state != S_IDLE) && (state != S_FIN);
  assign DONE = (state == S_FIN);

  always_comb begin
    nstate   = state;
    nidx     = idx;
    npoll    = poll_cnt;
    ngap     = gap_cnt;
    cap      = 1'b0;
    set_err  = 1'b0;
    load_dec = 1'b0;
    sh_we    = 1'b0;
    case (state)
      S_IDLE: if (START) begin
        cap    = 1'b1;
        nstate = S_WR_KEY;
        nidx   = 2'd0;
        npoll  = '0;
      end
      S_WR_KEY: if (xfer) begin
        nidx = idx + 2'd1;
        if (idx == 2'd3) nstate = S_WR_MSG;
      end
      S_WR_MSG: if (xfer) begin
        nidx = idx + 2'd1;
        if (idx == 2'd3) nstate = S_WR_START;
      end
      S_WR_START: if (xfer) nstate = S_POLL;
      S_POLL: if (xfer) begin
        if (AVM_READDATA[0]) begin
          nstate = S_RD_DEC;
          nidx   = 2'd0;
        end else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
          set_err = 1'b1;
          nstate  = S_CLR_START;
        end else begin
          npoll = poll_cnt + 1'b1;
          ngap  = '0;
          // With no gap configured the next poll follows immediately.
          nstate = (POLL_GAP == 0) ? S_POLL : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(POLL_GAP - 1)) nstate = S_POLL;
        else                              ngap   = gap_cnt + 1'b1;
      end
      S_RD_DEC: if (xfer) begin
        nidx = idx + 2'd1;
        if (idx == 2'd3) begin
          nstate   = S_CLR_START;
          load_dec = 1'b1;
        end else begin
          sh_we = 1'b1;
        end
      end
      S_CLR_START: if (xfer) nstate = S_FIN;
      S_FIN:       nstate = S_IDLE;
      default:     nstate = S_IDLE;
    endcase

    // Bus drive for the coming cycle is a pure function of the next state, so
    // a stalled transfer re-presents identical address/data/strobes.
    nrd   = 1'b0;
    nwr   = 1'b0;
    naddr = 4'd0;
    nwd   = 32'd0;
    case (nstate)
      S_WR_KEY: begin
        nwr = 1'b1; naddr = {2'b00, nidx}; nwd = word_of(cap ? KEY : key_q, nidx);
      end
      S_WR_MSG: begin
        nwr = 1'b1; naddr = {2'b01, nidx}; nwd = word_of(msg_q, nidx);
      end
      S_WR_START:  begin nwr = 1'b1; naddr = 4'd14; nwd = 32'd1; end
      S_POLL:      begin nrd = 1'b1; naddr = 4'd15; end
      S_RD_DEC:    begin nrd = 1'b1; naddr = {2'b10, nidx}; end
      S_CLR_START: begin nwr = 1'b1; naddr = 4'd14; nwd = 32'd0; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= S_IDLE;
      idx           <= 2'd0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      key_q         <= '0;
      msg_q         <= '0;
      sh0           <= '0;
      sh1           <= '0;
      sh2           <= '0;
      MSG_DEC       <= '0;
      ERR           <= 1'b0;
      AVM_CS        <= 1'b0;
      AVM_READ      <= 1'b0;
      AVM_WRITE     <= 1'b0;
      AVM_BYTE_EN   <= 4'b0000;
      AVM_ADDR      <= 4'd0;
      AVM_WRITEDATA <= 32'd0;
    end else begin
      state         <= nstate;
      idx           <= nidx;
      poll_cnt      <= npoll;
      gap_cnt       <= ngap;
      AVM_CS        <= nrd | nwr;
      AVM_READ      <= nrd;
      AVM_WRITE     <= nwr;
      AVM_BYTE_EN   <= {4{nrd | nwr}};
      AVM_ADDR      <= naddr;
      AVM_WRITEDATA <= nwd;
      if (cap) begin
        key_q <= KEY;
        msg_q <= MSG_ENC;
      end
      if (cap)          ERR <= 1'b0;
      else if (set_err) ERR <= 1'b1;
      if (sh_we) begin
        case (idx)
          2'd0:    sh0 <= AVM_READDATA;
          2'd1:    sh1 <= AVM_READDATA;
          default: sh2 <= AVM_READDATA;
        endcase
      end
      // Last plaintext word goes straight from the bus into the result.
      if (load_dec) MSG_DEC <= {sh0, sh1, sh2, AVM_READDATA};
    end
  end

endmodule

// File: tb/tb_avalon_aes_master.sv
// tb_avalon_aes_master
//   Directed bench for avalon_aes_master. Two instances: dut0 with default
//   parameters and dut1 with POLL_LIMIT=3 for the timeout case. A behavioural
//   slave (selected by sel) answers done polls and plaintext reads and can
//   inject 3-cycle waitrequest stalls on every third transfer.
module tb_avalon_aes_master;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] msg = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] DEC = 128'h00112233445566778899aabbccddeeff;

  logic [31:0]  rdata;
  logic         b_wait;

  logic [127:0] d0_dec, d1_dec;
  logic         d0_busy, d0_done, d0_err, d0_cs, d0_rd, d0_wr;
  logic         d1_busy, d1_done, d1_err, d1_cs, d1_rd, d1_wr;
  logic [3:0]   d0_be, d0_addr, d1_be, d1_addr;
  logic [31:0]  d0_wd, d1_wd;

  always #5 CLK = ~CLK;

  avalon_aes_master dut0 (
    .CLK(CLK), .RESET(RESET), .START(start & ~sel), .KEY(key), .MSG_ENC(msg),
    .MSG_DEC(d0_dec), .BUSY(d0_busy), .DONE(d0_done), .ERR(d0_err),
    .AVM_CS(d0_cs), .AVM_READ(d0_rd), .AVM_WRITE(d0_wr), .AVM_BYTE_EN(d0_be),
    .AVM_ADDR(d0_addr), .AVM_WRITEDATA(d0_wd), .AVM_READDATA(rdata),
    .AVM_WAITREQUEST(b_wait & ~sel)
  );

  avalon_aes_master #(.POLL_GAP(4), .POLL_LIMIT(3)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(start & sel), .KEY(key), .MSG_ENC(msg),
    .MSG_DEC(d1_dec), .BUSY(d1_busy), .DONE(d1_done), .ERR(d1_err),
    .AVM_CS(d1_cs), .AVM_READ(d1_rd), .AVM_WRITE(d1_wr), .AVM_BYTE_EN(d1_be),
    .AVM_ADDR(d1_addr), .AVM_WRITEDATA(d1_wd), .AVM_READDATA(rdata),
    .AVM_WAITREQUEST(b_wait & sel)
  );

  // Observed bus = selected instance
  logic [127:0] b_dec;
  logic         b_busy, b_done, b_err, b_cs, b_read, b_write;
  logic [3:0]   b_be, b_addr;
  logic [31:0]  b_wd;
  assign b_dec   = sel ? d1_dec  : d0_dec;
  assign b_busy  = sel ? d1_busy : d0_busy;
  assign b_done  = sel ? d1_done : d0_done;
  assign b_err   = sel ? d1_err  : d0_err;
  assign b_cs    = sel ? d1_cs   : d0_cs;
  assign b_read  = sel ? d1_rd   : d0_rd;
  assign b_write = sel ? d1_wr   : d0_wr;
  assign b_be    = sel ? d1_be   : d0_be;
  assign b_addr  = sel ? d1_addr : d0_addr;
  assign b_wd    = sel ? d1_wd   : d0_wd;

  // Slave model
  logic stall_en = 1'b0;
  logic slv_clr  = 1'b0;
  int   done_at  = 1;     // poll number that first sees done; 0 = never
  int   polls_seen, xfer_cnt, wait_ctr;

  always_comb b_wait = stall_en && (b_read || b_write) && (xfer_cnt % 3 == 2) && (wait_ctr < 3);

  always_comb begin
    rdata = 32'd0;
    case (b_addr)
      4'd15: rdata = {31'd0, (done_at != 0) && (polls_seen + 1 >= done_at)};
      4'd8:  rdata = DEC[127:96];
      4'd9:  rdata = DEC[95:64];
      4'd10: rdata = DEC[63:32];
      4'd11: rdata = DEC[31:0];
      default: rdata = 32'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (slv_clr) begin
      polls_seen <= 0; xfer_cnt <= 0; wait_ctr <= 0;
    end else if (b_read || b_write) begin
      if (b_wait) wait_ctr <= wait_ctr + 1;
      else begin
        xfer_cnt <= xfer_cnt + 1;
        wait_ctr <= 0;
        if (b_read && b_addr == 4'd15) polls_seen <= polls_seen + 1;
      end
    end
  end

  // Expected zero-wait, first-poll-done sequence (reads log the returned data)
  int          EA [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 14, 15, 8, 9, 10, 11, 14};
  int          EW [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
  logic [31:0] ED [15] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                           32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a,
                           32'h1, 32'h1,
                           32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                           32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  // Capture results (written only by run_seq)
  int           lg_addr[$];
  int           lg_wr[$];
  logic [31:0]  lg_data[$];
  int           lg_cyc[$];
  int           done_cycle, done_cnt, stall_viol, nstall;
  logic         err_at_done, busy_at_done, busy_c2, err_c2;
  logic [127:0] dec_at_done;

  // Pulses START, then records every completed transfer with its cycle number
  // (START cycle = 1) until 20 cycles after the first DONE or the budget ends.
  task automatic run_seq(input int budget, input bit poke);
    int cyc;
    bit prev_wait, poked;
    logic [3:0] p_addr, p_be;
    logic [31:0] p_wd;
    logic p_rd, p_wr;
    lg_addr.delete(); lg_wr.delete(); lg_data.delete(); lg_cyc.delete();
    done_cycle = -1; done_cnt = 0; stall_viol = 0; nstall = 0;
    err_at_done = 1'bx; busy_at_done = 1'bx; dec_at_done = 'x;
    prev_wait = 0; poked = 0;
    p_addr = 0; p_be = 0; p_wd = 0; p_rd = 0; p_wr = 0;
    @(negedge CLK) slv_clr = 1'b1;
    @(negedge CLK) slv_clr = 1'b0;
    start = 1'b1;
    @(negedge CLK) start = 1'b0;
    cyc = 2;
    busy_c2 = b_busy;
    err_c2  = b_err;
    while (cyc < budget) begin
      if (prev_wait && (b_addr !== p_addr || b_wd !== p_wd || b_read !== p_rd ||
                        b_write !== p_wr || b_be !== p_be))
        stall_viol++;
      if (b_wait) nstall++;
      prev_wait = b_wait;
      p_addr = b_addr; p_wd = b_wd; p_rd = b_read; p_wr = b_write; p_be = b_be;
      if ((b_read || b_write) && !b_wait) begin
        lg_addr.push_back(int'(b_addr));
        lg_wr.push_back(b_write ? 1 : 0);
        lg_data.push_back(b_write ? b_wd : rdata);
        lg_cyc.push_back(cyc);
      end
      if (b_done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = cyc; err_at_done = b_err; busy_at_done = b_busy; dec_at_done = b_dec;
          if (poke) start = 1'b1;
        end
      end else if (poke && !poked && b_read && b_addr == 4'd15) begin
        start = 1'b1; poked = 1;
      end
      @(negedge CLK) start = 1'b0;
      cyc++;
      if (done_cycle >= 0 && cyc > done_cycle + 20) break;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #1;
    n_checks++;
    if ({d0_dec, d0_busy, d0_done, d0_err, d0_cs, d0_rd, d0_wr, d0_be, d0_addr, d0_wd} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: outputs not all zero, dec=%h be=%b addr=%0d", d0_dec, d0_be, d0_addr);
    end
    n_checks++;
    if ({d1_dec, d1_busy, d1_done, d1_err, d1_cs, d1_rd, d1_wr, d1_be, d1_addr, d1_wd} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: outputs not all zero, dec=%h be=%b addr=%0d", d1_dec, d1_be, d1_addr);
    end
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({d0_busy, d0_done, d0_cs, d0_be} !== 7'd0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b cs=%b be=%b, expected all 0", d0_busy, d0_done, d0_cs, d0_be);
    end
  endtask

  task automatic test_zero_wait();
    sel = 1'b0; stall_en = 1'b0; done_at = 1;
    run_seq(200, 0);
    n_checks++;
    if (lg_addr.size() != 15) begin
      n_fail++; $display("FAIL zw_count: got %0d transfers, expected 15", lg_addr.size());
    end
    for (int i = 0; i < 15 && i < lg_addr.size(); i++) begin
      n_checks++;
      if (lg_addr[i] != EA[i] || lg_wr[i] != EW[i] || lg_data[i] !== ED[i] || lg_cyc[i] != i + 2) begin
        n_fail++;
        $display("FAIL zw_xfer[%0d]: addr %0d wr %0d data %h cyc %0d, expected addr %0d wr %0d data %h cyc %0d",
                 i, lg_addr[i], lg_wr[i], lg_data[i], lg_cyc[i], EA[i], EW[i], ED[i], i + 2);
      end
    end
    n_checks++;
    if (done_cycle != 17) begin n_fail++; $display("FAIL zw_done_cycle: got %0d expected 17", done_cycle); end
    n_checks++;
    if (dec_at_done !== DEC) begin n_fail++; $display("FAIL zw_msg_dec: got %h expected %h", dec_at_done, DEC); end
    n_checks++;
    if (busy_c2 !== 1'b1 || busy_at_done !== 1'b0 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL zw_status: busy@2=%b busy@done=%b err=%b, expected 1 0 0", busy_c2, busy_at_done, err_at_done);
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL zw_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_waitrequest();
    sel = 1'b0; stall_en = 1'b1; done_at = 1;
    run_seq(300, 0);
    stall_en = 1'b0;
    n_checks++;
    if (lg_addr.size() != 15) begin
      n_fail++; $display("FAIL wr_count: got %0d transfers, expected 15", lg_addr.size());
    end
    for (int i = 0; i < 15 && i < lg_addr.size(); i++) begin
      n_checks++;
      if (lg_addr[i] != EA[i] || lg_wr[i] != EW[i] || lg_data[i] !== ED[i]) begin
        n_fail++;
        $display("FAIL wr_xfer[%0d]: addr %0d wr %0d data %h, expected addr %0d wr %0d data %h",
                 i, lg_addr[i], lg_wr[i], lg_data[i], EA[i], EW[i], ED[i]);
      end
    end
    n_checks++;
    if (stall_viol != 0) begin n_fail++; $display("FAIL wr_stable: %0d bus changes during stall, expected 0", stall_viol); end
    n_checks++;
    if (nstall != 15) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d expected 15", nstall); end
    n_checks++;
    if (done_cycle != 32) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected 32", done_cycle); end
    n_checks++;
    if (dec_at_done !== DEC) begin n_fail++; $display("FAIL wr_msg_dec: got %h expected %h", dec_at_done, DEC); end
  endtask

  task automatic test_delayed_done();
    int np, lastc;
    sel = 1'b0; stall_en = 1'b0; done_at = 5;
    run_seq(300, 0);
    np = 0; lastc = 0;
    for (int i = 0; i < lg_addr.size(); i++) begin
      if (lg_addr[i] == 15 && lg_wr[i] == 0) begin
        if (np > 0) begin
          n_checks++;
          if (lg_cyc[i] - lastc != 5) begin
            n_fail++; $display("FAIL dd_spacing[%0d]: poll gap %0d cycles, expected 5", np, lg_cyc[i] - lastc);
          end
        end
        np++; lastc = lg_cyc[i];
      end
    end
    n_checks++;
    if (np != 5) begin n_fail++; $display("FAIL dd_polls: got %0d expected 5", np); end
    n_checks++;
    if (lg_addr.size() != 19) begin n_fail++; $display("FAIL dd_count: got %0d transfers, expected 19", lg_addr.size()); end
    n_checks++;
    if (done_cycle != 37) begin n_fail++; $display("FAIL dd_done_cycle: got %0d expected 37", done_cycle); end
    n_checks++;
    if (err_at_done !== 1'b0 || dec_at_done !== DEC) begin
      n_fail++; $display("FAIL dd_result: err=%b dec=%h, expected 0 %h", err_at_done, dec_at_done, DEC);
    end
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0; stall_en = 1'b0; done_at = 2;
    run_seq(300, 1);
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL sb_done_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (lg_addr.size() != 16) begin n_fail++; $display("FAIL sb_count: got %0d transfers, expected 16", lg_addr.size()); end
    n_checks++;
    if (done_cycle != 22) begin n_fail++; $display("FAIL sb_done_cycle: got %0d expected 22", done_cycle); end
    n_checks++;
    if (b_busy !== 1'b0 || b_read !== 1'b0 || b_write !== 1'b0) begin
      n_fail++; $display("FAIL sb_idle_after: busy=%b rd=%b wr=%b, expected 0 0 0", b_busy, b_read, b_write);
    end
  endtask

  task automatic test_timeout();
    int np;
    sel = 1'b1; stall_en = 1'b0; done_at = 1;
    run_seq(200, 0);
    n_checks++;
    if (dec_at_done !== DEC) begin n_fail++; $display("FAIL to_prime: dec=%h expected %h", dec_at_done, DEC); end
    done_at = 0;
    run_seq(200, 0);
    np = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == 15 && lg_wr[i] == 0) np++;
    n_checks++;
    if (np != 3) begin n_fail++; $display("FAIL to_polls: got %0d expected 3", np); end
    n_checks++;
    if (lg_addr.size() != 13) begin
      n_fail++; $display("FAIL to_count: got %0d transfers, expected 13", lg_addr.size());
    end else if (lg_addr[12] != 14 || lg_wr[12] != 1 || lg_data[12] !== 32'h0) begin
      n_fail++; $display("FAIL to_clear: addr %0d wr %0d data %h, expected 14 1 0", lg_addr[12], lg_wr[12], lg_data[12]);
    end
    n_checks++;
    if (done_cycle != 23 || err_at_done !== 1'b1) begin
      n_fail++; $display("FAIL to_done: cycle %0d err %b, expected 23 1", done_cycle, err_at_done);
    end
    n_checks++;
    if (dec_at_done !== DEC) begin n_fail++; $display("FAIL to_msg_kept: got %h expected %h", dec_at_done, DEC); end
    n_checks++;
    if (b_err !== 1'b1) begin n_fail++; $display("FAIL to_err_held: got %b expected 1", b_err); end
    done_at = 1;
    run_seq(200, 0);
    n_checks++;
    if (err_c2 !== 1'b0 || err_at_done !== 1'b0 || done_cycle != 17) begin
      n_fail++; $display("FAIL to_err_clear: err@2=%b err@done=%b cycle=%0d, expected 0 0 17", err_c2, err_at_done, done_cycle);
    end
  endtask

  task automatic test_reset_midrun();
    bit found;
    sel = 1'b0; stall_en = 1'b0; done_at = 1;
    @(negedge CLK) slv_clr = 1'b1;
    @(negedge CLK) slv_clr = 1'b0;
    start = 1'b1;
    @(negedge CLK) start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (b_write && b_addr == 4'd2) found = 1;
      else @(negedge CLK);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rm_find: third key write not seen, got 0 expected 1"); end
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({b_cs, b_read, b_write, b_be} !== 7'd0) begin
      n_fail++; $display("FAIL rm_strobes: cs=%b rd=%b wr=%b be=%b, expected all 0", b_cs, b_read, b_write, b_be);
    end
    n_checks++;
    if ({b_dec, b_busy, b_done, b_err, b_addr, b_wd} !== '0) begin
      n_fail++; $display("FAIL rm_outputs: dec=%h busy=%b addr=%0d wd=%h, expected 0", b_dec, b_busy, b_addr, b_wd);
    end
    @(negedge CLK) RESET = 1'b1;
    run_seq(200, 0);
    n_checks++;
    if (lg_addr.size() != 15 || lg_addr[0] != 0 || lg_data[0] !== 32'h00010203) begin
      n_fail++; $display("FAIL rm_restart: %0d transfers, first addr %0d, expected 15 from addr 0", lg_addr.size(), lg_addr[0]);
    end
    n_checks++;
    if (done_cycle != 17 || dec_at_done !== DEC) begin
      n_fail++; $display("FAIL rm_result: cycle %0d dec %h, expected 17 %h", done_cycle, dec_at_done, DEC);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_waitrequest();
    test_delayed_done();
    test_start_while_busy();
    test_timeout();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
